// File: rtl/mips_bus_arbiter.sv
// Two-master (instruction fetch / load-store) to one-slave Avalon-style bus arbiter.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; default is data-port priority.
module mips_bus_arbiter #(
  parameter int unsigned WAIT_TIMEOUT = 1024,
  parameter logic [31:0] ERR_DATA     = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  output logic        i_readdatavalid,
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  output logic        d_readdatavalid,
  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic [3:0]  m_byteenable,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic        bus_error
);

  localparam int unsigned CW = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RDATA_I, RDATA_D} state_t;

  state_t        state, state_n;
  logic [CW-1:0] wait_cnt;
  logic          last_grant_d;
  logic          rd_err;
  logic          busy;
  logic          timeout;
  logic          d_cmd;
  logic          d_wins;

  assign busy    = (state == BUSY_I) || (state == BUSY_D);
  assign timeout = (WAIT_TIMEOUT != 0) && (wait_cnt == CW'(WAIT_TIMEOUT));
  assign d_cmd   = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  assign d_wins = ~last_grant_d;
`else
  // Fixed priority: the data port takes every tie; last_grant_d has no effect here.
  assign d_wins = 1'b1 | last_grant_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      bus_error    <= 1'b0;
      last_grant_d <= 1'b1;
      rd_err       <= 1'b0;
    end else begin
      state <= state_n;
      if (busy) begin
        if (m_waitrequest && !timeout && (wait_cnt != '1))
          wait_cnt <= wait_cnt + CW'(1);
        rd_err <= timeout;
        if (timeout)
          bus_error <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if ((state == IDLE) && (state_n != IDLE))
        last_grant_d <= (state_n == BUSY_D);
    end
  end

  always_comb begin
    state_n         = state;
    m_address       = '0;
    m_read          = 1'b0;
    m_write         = 1'b0;
    m_writedata     = '0;
    m_byteenable    = '0;
    i_waitrequest   = 1'b1;
    d_waitrequest   = 1'b1;
    i_readdata      = '0;
    d_readdata      = '0;
    i_readdatavalid = 1'b0;
    d_readdatavalid = 1'b0;
    case (state)
      IDLE: begin
        if (i_read && d_cmd)
          state_n = d_wins ? BUSY_D : BUSY_I;
        else if (i_read)
          state_n = BUSY_I;
        else if (d_cmd)
          state_n = BUSY_D;
      end
      BUSY_I: begin
        m_address     = i_address;
        m_read        = i_read & ~timeout;
        m_byteenable  = '1;
        i_waitrequest = m_waitrequest & ~timeout;
        if (!i_read)
          state_n = IDLE;
        else if (timeout || !m_waitrequest)
          state_n = RDATA_I;
      end
      BUSY_D: begin
        // A simultaneous read+write is forwarded as the write alone.
        m_address     = d_address;
        m_write       = d_write & ~timeout;
        m_read        = d_read & ~d_write & ~timeout;
        m_writedata   = d_writedata;
        m_byteenable  = d_byteenable;
        d_waitrequest = m_waitrequest & ~timeout;
        if (!d_cmd)
          state_n = IDLE;
        else if (timeout || !m_waitrequest)
          state_n = d_write ? IDLE : RDATA_D;
      end
      RDATA_I: begin
        i_readdata      = rd_err ? ERR_DATA : m_readdata;
        i_readdatavalid = 1'b1;
        state_n         = IDLE;
      end
      RDATA_D: begin
        d_readdata      = rd_err ? ERR_DATA : m_readdata;
        d_readdatavalid = 1'b1;
        state_n         = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
